// File: rtl/zports_pkg.sv
// Shared register map and bit positions for the zports register block.
package zports_pkg;

    typedef enum logic [1:0] {
        ADDR_SL811D = 2'd0,
        ADDR_CFG    = 2'd1,
        ADDR_INT    = 2'd2,
        ADDR_RST    = 2'd3
    } reg_addr_e;

    localparam int unsigned CFG_ROM_ENA     = 0;
    localparam int unsigned CFG_ROM_WIN     = 1;
    localparam int unsigned CFG_W5300_PORTS = 4;

    localparam int unsigned INT_FLAG_LSB = 0;
    localparam int unsigned INT_EN_LSB   = 2;
    localparam int unsigned INT_RAW_LSB  = 4;

    localparam int unsigned RST_W5300 = 0;
    localparam int unsigned RST_SL811 = 1;

    localparam logic [7:0] RD_RESERVED = 8'hFF;

endpackage

// File: rtl/zports_zsync2.sv
// Two-flop synchronizer with asynchronous high reset to a configurable value.
module zsync2 #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/zports.sv
// fclk-side port register block: CFG/INT/RST registers written from the
// asynchronous Z80 port bus, interrupt latching and timed chip resets.
module zports
    import zports_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 1024
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       ports_wrena,
    input  logic       ports_wrstb_n,
    input  logic [1:0] ports_addr,
    input  logic [7:0] ports_wrdata,
    output logic [7:0] ports_rddata,
    output logic [1:0] rommap_win,
    output logic       rommap_ena,
    output logic       w5300_ports,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    output logic       zint_n,
    output logic       w5300_rst_n,
    output logic       sl811_rst_n
);

    localparam logic [15:0] CNT_LOAD = 16'(RST_CYCLES - 1);

    logic       stb_sync;
    logic       stb_hist;
    logic       commit;
    reg_addr_e  sel;
    logic       wr_cfg;
    logic       wr_int;
    logic       wr_rst;

    logic       w5300_sync_n;
    logic       sl811_sync;
    logic [1:0] raw_sync;
    logic [1:0] int_prev;
    logic [1:0] int_flag;
    logic [1:0] int_en;
    logic [1:0] int_rise;
    logic [1:0] int_clr;

    logic [1:0]  rst_mask;
    logic [15:0] rst_cnt;
    logic        cnt_live;

    logic unused_wrdata_bits;
    assign unused_wrdata_bits = &{1'b0, ports_wrdata[7:5]};

    zsync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_stb_sync (
        .clk (fclk),
        .rst (rst),
        .d   (ports_wrstb_n),
        .q   (stb_sync)
    );

    zsync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_w5300_sync (
        .clk (fclk),
        .rst (rst),
        .d   (w5300_int_n),
        .q   (w5300_sync_n)
    );

    zsync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sl811_sync (
        .clk (fclk),
        .rst (rst),
        .d   (sl811_intrq),
        .q   (sl811_sync)
    );

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            stb_hist <= 1'b1;
        end else begin
            stb_hist <= stb_sync;
        end
    end

    // Address/data are sampled raw: they have been stable for the whole
    // synchronizer delay by the time the falling strobe edge is seen.
    always_comb begin
        sel    = reg_addr_e'(ports_addr);
        commit = ~stb_sync & stb_hist & ports_wrena;
        wr_cfg = commit && (sel == ADDR_CFG);
        wr_int = commit && (sel == ADDR_INT);
        wr_rst = commit && (sel == ADDR_RST);
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            rommap_ena  <= 1'b0;
            rommap_win  <= 2'b00;
            w5300_ports <= 1'b0;
        end else if (wr_cfg) begin
            rommap_ena  <= ports_wrdata[CFG_ROM_ENA];
            rommap_win  <= ports_wrdata[CFG_ROM_WIN +: 2];
            w5300_ports <= ports_wrdata[CFG_W5300_PORTS];
        end
    end

    always_comb begin
        raw_sync = {sl811_sync, ~w5300_sync_n};
        int_rise = raw_sync & ~int_prev;
        int_clr  = wr_int ? ports_wrdata[INT_FLAG_LSB +: 2] : '0;
    end

    // Rising edge is ORed in after the clear so a coincident edge survives.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            int_prev <= '0;
            int_flag <= '0;
            int_en   <= '0;
            zint_n   <= 1'b1;
        end else begin
            int_prev <= raw_sync;
            int_flag <= (int_flag & ~int_clr) | int_rise;
            if (wr_int) begin
                int_en <= ports_wrdata[INT_EN_LSB +: 2];
            end
            zint_n <= ~|(int_flag & int_en);
        end
    end

    assign cnt_live = (rst_cnt != '0);

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            rst_mask    <= '1;
            rst_cnt     <= CNT_LOAD;
            w5300_rst_n <= 1'b0;
            sl811_rst_n <= 1'b0;
        end else begin
            if (wr_rst && (ports_wrdata[1:0] != 2'b00)) begin
                rst_mask <= rst_mask | ports_wrdata[1:0];
                rst_cnt  <= CNT_LOAD;
            end else if (cnt_live) begin
                rst_cnt <= rst_cnt - 16'd1;
            end else begin
                rst_mask <= '0;
            end
            w5300_rst_n <= ~(rst_mask[RST_W5300] & cnt_live);
            sl811_rst_n <= ~(rst_mask[RST_SL811] & cnt_live);
        end
    end

    always_comb begin
        ports_rddata = RD_RESERVED;
        case (sel)
            ADDR_CFG: begin
                ports_rddata                     = '0;
                ports_rddata[CFG_ROM_ENA]        = rommap_ena;
                ports_rddata[CFG_ROM_WIN +: 2]   = rommap_win;
                ports_rddata[CFG_W5300_PORTS]    = w5300_ports;
            end
            ADDR_INT: begin
                ports_rddata                     = '0;
                ports_rddata[INT_FLAG_LSB +: 2]  = int_flag;
                ports_rddata[INT_EN_LSB +: 2]    = int_en;
                ports_rddata[INT_RAW_LSB +: 2]   = raw_sync;
            end
            ADDR_RST: begin
                ports_rddata      = '0;
                ports_rddata[1:0] = rst_mask;
            end
            default: ports_rddata = RD_RESERVED;
        endcase
    end

endmodule

// File: tb/tb_zports.sv
// Scoreboard bench for zports: stimulus queues timed expectations, a monitor
// compares them against the DUT one time unit after each rising fclk edge.
module tb_zports;

    localparam int unsigned R = 16;

    localparam int unsigned SEL_RD    = 0;
    localparam int unsigned SEL_ZINT  = 1;
    localparam int unsigned SEL_WRST  = 2;
    localparam int unsigned SEL_SRST  = 3;
    localparam int unsigned SEL_CFGO  = 4;

    logic       fclk = 1'b0;
    logic       rst = 1'b1;
    logic       ports_wrena = 1'b0;
    logic       ports_wrstb_n = 1'b1;
    logic [1:0] ports_addr = 2'd0;
    logic [7:0] ports_wrdata = 8'h00;
    logic [7:0] ports_rddata;
    logic [1:0] rommap_win;
    logic       rommap_ena;
    logic       w5300_ports;
    logic       w5300_int_n = 1'b1;
    logic       sl811_intrq = 1'b0;
    logic       zint_n;
    logic       w5300_rst_n;
    logic       sl811_rst_n;

    zports #(.RST_CYCLES(R)) dut (
        .fclk          (fclk),
        .rst           (rst),
        .ports_wrena   (ports_wrena),
        .ports_wrstb_n (ports_wrstb_n),
        .ports_addr    (ports_addr),
        .ports_wrdata  (ports_wrdata),
        .ports_rddata  (ports_rddata),
        .rommap_win    (rommap_win),
        .rommap_ena    (rommap_ena),
        .w5300_ports   (w5300_ports),
        .w5300_int_n   (w5300_int_n),
        .sl811_intrq   (sl811_intrq),
        .zint_n        (zint_n),
        .w5300_rst_n   (w5300_rst_n),
        .sl811_rst_n   (sl811_rst_n)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        int unsigned due;
        int unsigned sel;
        logic [7:0]  exp;
        string       name;
    } chk_t;

    chk_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [7:0] observe(input int unsigned s);
        case (s)
            SEL_RD:   return ports_rddata;
            SEL_ZINT: return {7'd0, zint_n};
            SEL_WRST: return {7'd0, w5300_rst_n};
            SEL_SRST: return {7'd0, sl811_rst_n};
            default:  return {3'd0, w5300_ports, 1'b0, rommap_win, rommap_ena};
        endcase
    endfunction

    task automatic expect_at(input int unsigned due, input int unsigned s,
                             input logic [7:0] exp, input string name);
        chk_t c;
        c.due  = due;
        c.sel  = s;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    initial begin
        logic [7:0] act;
        forever begin
            @(posedge fclk);
            cyc++;
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due <= cyc) begin
                    act = observe(sb[i].sel);
                    checks++;
                    if (sb[i].due < cyc) begin
                        failures++;
                        $display("FAIL %s: stale expectation due %0d, seen at cycle %0d", sb[i].name, sb[i].due, cyc);
                    end else if (act !== sb[i].exp) begin
                        failures++;
                        $display("FAIL %s: got %02h expected %02h at cycle %0d", sb[i].name, act, sb[i].exp, cyc);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    // All tasks start and end right after a falling fclk edge.
    task automatic wr(input logic ena, input logic [1:0] a, input logic [7:0] d,
                      input int unsigned lo, input int unsigned hi);
        ports_wrena   = ena;
        ports_addr    = a;
        ports_wrdata  = d;
        ports_wrstb_n = 1'b0;
        repeat (lo) @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (hi) @(negedge fclk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        ports_addr = a;
        expect_at(cyc + 1, SEL_RD, exp, name);
        @(negedge fclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned t2;
        logic [7:0]  cfg_model;
        logic [1:0]  a;
        logic        ena;
        logic [7:0]  d;

        repeat (3) @(negedge fclk);
        t = cyc;
        rst = 1'b0;
        expect_at(t + 1,     SEL_WRST, 8'h00, "rst_w5300_early");
        expect_at(t + 1,     SEL_SRST, 8'h00, "rst_sl811_early");
        expect_at(t + R - 1, SEL_WRST, 8'h00, "rst_w5300_last_low");
        expect_at(t + R - 1, SEL_SRST, 8'h00, "rst_sl811_last_low");
        expect_at(t + R,     SEL_WRST, 8'h01, "rst_w5300_release");
        expect_at(t + R,     SEL_SRST, 8'h01, "rst_sl811_release");
        expect_at(t + 1,     SEL_ZINT, 8'h01, "rst_zint_n");
        expect_at(t + 1,     SEL_CFGO, 8'h00, "rst_cfg_outputs");
        rd(2'd1, 8'h00, "rst_cfg_read");
        repeat (R + 2) @(negedge fclk);

        t = cyc;
        expect_at(t + 4, SEL_CFGO, 8'h17, "cfg_write_outputs");
        wr(1'b1, 2'd1, 8'h17, 6, 4);
        rd(2'd1, 8'h17, "cfg_read");
        cfg_model = 8'h17;

        wr(1'b0, 2'd1, 8'hFF, 6, 4);
        rd(2'd1, 8'h17, "decode_miss_cfg");
        wr(1'b1, 2'd0, 8'hA5, 6, 4);
        rd(2'd0, 8'hFF, "addr0_read");
        rd(2'd1, 8'h17, "addr0_write_ignored");

        wr(1'b1, 2'd2, 8'h04, 6, 4);
        t = cyc;
        w5300_int_n = 1'b0;
        expect_at(t + 3, SEL_ZINT, 8'h01, "int_zint_not_yet");
        expect_at(t + 4, SEL_ZINT, 8'h00, "int_zint_asserted");
        repeat (6) @(negedge fclk);
        rd(2'd2, 8'h15, "int_read_set");
        t = cyc;
        expect_at(t + 3, SEL_ZINT, 8'h00, "int_zint_before_clear");
        expect_at(t + 4, SEL_ZINT, 8'h01, "int_zint_cleared");
        wr(1'b1, 2'd2, 8'h05, 6, 4);
        repeat (6) @(negedge fclk);
        rd(2'd2, 8'h14, "int_no_reset_level");
        expect_at(cyc + 1, SEL_ZINT, 8'h01, "int_zint_stays_high");
        w5300_int_n = 1'b1;
        repeat (5) @(negedge fclk);

        sl811_intrq = 1'b1;
        repeat (5) @(negedge fclk);
        rd(2'd2, 8'h26, "sl811_flag_set");
        sl811_intrq = 1'b0;
        repeat (5) @(negedge fclk);
        rd(2'd2, 8'h06, "sl811_flag_held");
        sl811_intrq = 1'b1;
        wr(1'b1, 2'd2, 8'h02, 6, 4);
        rd(2'd2, 8'h22, "collision_set_wins");
        sl811_intrq = 1'b0;
        repeat (5) @(negedge fclk);

        t = cyc;
        expect_at(t + 3, SEL_WRST, 8'h01, "pulse1_w5300_before");
        expect_at(t + 4, SEL_WRST, 8'h00, "pulse1_w5300_low");
        expect_at(t + 4, SEL_SRST, 8'h01, "pulse1_sl811_high");
        expect_at(t + 3 + R, SEL_WRST, 8'h00, "pulse1_extended");
        wr(1'b1, 2'd3, 8'h01, 6, 4);
        rd(2'd3, 8'h01, "pulse1_busy");
        t2 = cyc;
        expect_at(t2 + 3,     SEL_SRST, 8'h01, "pulse2_sl811_before");
        expect_at(t2 + 4,     SEL_SRST, 8'h00, "pulse2_sl811_low");
        expect_at(t2 + 2 + R, SEL_WRST, 8'h00, "pulse2_w5300_last_low");
        expect_at(t2 + 2 + R, SEL_SRST, 8'h00, "pulse2_sl811_last_low");
        expect_at(t2 + 3 + R, SEL_WRST, 8'h01, "pulse2_w5300_release");
        expect_at(t2 + 3 + R, SEL_SRST, 8'h01, "pulse2_sl811_release");
        wr(1'b1, 2'd3, 8'h02, 6, 4);
        rd(2'd3, 8'h03, "pulse2_busy");
        repeat (R + 4) @(negedge fclk);
        rd(2'd3, 8'h00, "pulse_done_busy");
        t = cyc;
        expect_at(t + 5, SEL_WRST, 8'h01, "zero_write_w5300");
        expect_at(t + 5, SEL_SRST, 8'h01, "zero_write_sl811");
        wr(1'b1, 2'd3, 8'h00, 6, 4);
        rd(2'd3, 8'h00, "zero_write_busy");

        for (int n = 0; n < 40; n++) begin
            a   = 2'($urandom_range(1, 0));
            ena = ($urandom_range(3, 0) != 0);
            d   = 8'($urandom);
            if (ena && a == 2'd1) cfg_model = d & 8'h17;
            t = cyc;
            expect_at(t + 4, SEL_CFGO, cfg_model, "rand_cfg_outputs");
            wr(ena, a, d, $urandom_range(8, 3), $urandom_range(6, 3));
            rd(2'd1, cfg_model, "rand_cfg_read");
            if (a == 2'd0) rd(2'd0, 8'hFF, "rand_addr0_read");
        end

        for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge fclk);
        while (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: never checked, due cycle %0d", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
